// File: rtl/microwave_timer.sv
// Microwave countdown timer: BCD keypad entry into an M:SS setting, a per-second
// countdown while the magnetron is on, a 0:00 level flag and a one-cycle completion pulse.
module microwave_timer #(
    parameter int unsigned TICKS_PER_SEC = 100
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clearn,
    input  logic       keypad_valid,
    input  logic [3:0] keypad_digit,
    input  logic       mag_on,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic       timer_done,
    output logic       done_pulse
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] LastTick = PW'(TICKS_PER_SEC - 1);

    logic [3:0]    r_sec_ones, r_sec_tens, r_min_ones;
    logic [3:0]    w_sec_ones, w_sec_tens, w_min_ones;
    logic [PW-1:0] r_presc, w_presc;
    logic          r_done, w_done;
    logic          w_zero;
    logic          w_wrap;
    logic          w_entry;

    assign w_zero  = (r_sec_ones == 4'd0) && (r_sec_tens == 4'd0) && (r_min_ones == 4'd0);
    assign w_wrap  = (r_presc == LastTick);
    assign w_entry = keypad_valid && !mag_on && (keypad_digit <= 4'd9);

    // Next-state: clear, then entry, then countdown, otherwise hold.
    always_comb begin
        w_sec_ones = r_sec_ones;
        w_sec_tens = r_sec_tens;
        w_min_ones = r_min_ones;
        w_presc    = r_presc;
        w_done     = 1'b0;
        if (!clearn) begin
            w_sec_ones = 4'd0;
            w_sec_tens = 4'd0;
            w_min_ones = 4'd0;
            w_presc    = '0;
        end else if (w_entry) begin
            w_min_ones = r_sec_tens;
            w_sec_tens = r_sec_ones;
            w_sec_ones = keypad_digit;
            w_presc    = '0;
        end else if (mag_on && !w_zero) begin
            if (w_wrap) begin
                w_presc = '0;
                if (r_sec_ones != 4'd0) begin
                    w_sec_ones = r_sec_ones - 4'd1;
                end else if (r_sec_tens != 4'd0) begin
                    w_sec_ones = 4'd9;
                    w_sec_tens = r_sec_tens - 4'd1;
                end else begin
                    w_sec_ones = 4'd9;
                    w_sec_tens = 4'd5;
                    w_min_ones = r_min_ones - 4'd1;
                end
                // Only 0:01 decrements into 0:00.
                w_done = (r_min_ones == 4'd0) && (r_sec_tens == 4'd0) && (r_sec_ones == 4'd1);
            end else begin
                w_presc = r_presc + 1'b1;
            end
        end
    end

    // State registers with asynchronous reset to 0:00.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sec_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_presc    <= '0;
            r_done     <= 1'b0;
        end else begin
            r_sec_ones <= w_sec_ones;
            r_sec_tens <= w_sec_tens;
            r_min_ones <= w_min_ones;
            r_presc    <= w_presc;
            r_done     <= w_done;
        end
    end

    assign sec_ones   = r_sec_ones;
    assign sec_tens   = r_sec_tens;
    assign min_ones   = r_min_ones;
    assign timer_done = w_zero;
    assign done_pulse = r_done;

endmodule

// File: tb/tb_microwave_timer.sv
// Self-checking bench for microwave_timer with TICKS_PER_SEC = 4.
module tb_microwave_timer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       clearn;
    logic       keypad_valid;
    logic [3:0] keypad_digit;
    logic       mag_on;
    logic [3:0] sec_ones, sec_tens, min_ones;
    logic       timer_done, done_pulse;

    int tests = 0;
    int fails = 0;

    microwave_timer #(.TICKS_PER_SEC(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .clearn       (clearn),
        .keypad_valid (keypad_valid),
        .keypad_digit (keypad_digit),
        .mag_on       (mag_on),
        .sec_ones     (sec_ones),
        .sec_tens     (sec_tens),
        .min_ones     (min_ones),
        .timer_done   (timer_done),
        .done_pulse   (done_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       clearn;
        logic       kv;
        logic [3:0] digit;
        logic       mag;
        logic [3:0] em;
        logic [3:0] et;
        logic [3:0] eo;
        logic       ed;
        logic       ep;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [3:0] em, input logic [3:0] et,
                         input logic [3:0] eo, input logic ed, input logic ep);
        tests++;
        if (min_ones !== em || sec_tens !== et || sec_ones !== eo ||
            timer_done !== ed || done_pulse !== ep) begin
            fails++;
            $display("FAIL %s: got %0h:%0h%0h done=%b pulse=%b, want %0h:%0h%0h done=%b pulse=%b",
                     name, min_ones, sec_tens, sec_ones, timer_done, done_pulse,
                     em, et, eo, ed, ep);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic enter(input logic [3:0] d);
        keypad_valid = 1'b1;
        keypad_digit = d;
        step(1);
        keypad_valid = 1'b0;
    endtask

    task automatic do_clear();
        mag_on = 1'b0;
        clearn = 1'b0;
        step(1);
        clearn = 1'b1;
    endtask

    initial begin
        int secs;
        logic [3:0] em, et, eo;

        vecs[0]  = '{1'b1, 1'b1, 4'd1,  1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 4'd3,  1'b0, 4'd0, 4'd1, 4'd3, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 4'd0,  1'b0, 4'd1, 4'd3, 4'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 4'd12, 1'b0, 4'd1, 4'd3, 4'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 4'd5,  1'b0, 4'd1, 4'd3, 4'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 4'd5,  1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 4'd0,  1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 4'd9,  1'b0, 4'd0, 4'd0, 4'd9, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 4'd9,  1'b0, 4'd0, 4'd9, 4'd9, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 4'd4,  1'b0, 4'd9, 4'd9, 4'd4, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 4'd7,  1'b1, 4'd9, 4'd9, 4'd4, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 4'd15, 1'b0, 4'd9, 4'd9, 4'd4, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 4'd0,  1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0};

        resetn       = 1'b0;
        clearn       = 1'b1;
        keypad_valid = 1'b0;
        keypad_digit = 4'd0;
        mag_on       = 1'b0;
        #2;
        check("reset_async", 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        step(2);
        check("reset_held", 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        resetn = 1'b1;

        // Table: entry, illegal digit, clear, blocked entry while cooking.
        for (int i = 0; i < 13; i++) begin
            clearn       = vecs[i].clearn;
            keypad_valid = vecs[i].kv;
            keypad_digit = vecs[i].digit;
            mag_on       = vecs[i].mag;
            step(1);
            check($sformatf("vec%0d", i), vecs[i].em, vecs[i].et, vecs[i].eo,
                  vecs[i].ed, vecs[i].ep);
        end
        clearn = 1'b1;
        keypad_valid = 1'b0;
        mag_on = 1'b0;

        // Countdown 1:00 to 0:00 with borrow, single pulse, then hold.
        do_clear();
        enter(4'd1); enter(4'd0); enter(4'd0);
        check("load_100", 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);
        mag_on = 1'b1;
        secs = 60;
        for (int k = 1; k <= 248; k++) begin
            step(1);
            if (k % 4 == 0 && k <= 240) secs--;
            em = 4'(secs / 60);
            et = 4'((secs % 60) / 10);
            eo = 4'(secs % 10);
            if (k == 3 || k == 4 || k % 40 == 0 || k >= 239)
                check($sformatf("count_k%0d", k), em, et, eo, secs == 0, k == 240);
        end
        mag_on = 1'b0;

        // Pause and resume keeps the partial second.
        do_clear();
        enter(4'd5);
        mag_on = 1'b1;
        step(6);
        check("pause_run6", 4'd0, 4'd0, 4'd4, 1'b0, 1'b0);
        mag_on = 1'b0;
        step(10);
        check("pause_hold", 4'd0, 4'd0, 4'd4, 1'b0, 1'b0);
        mag_on = 1'b1;
        step(1);
        check("resume_1", 4'd0, 4'd0, 4'd4, 1'b0, 1'b0);
        step(1);
        check("resume_2", 4'd0, 4'd0, 4'd3, 1'b0, 1'b0);

        // Seconds above 59 count down decimally.
        do_clear();
        enter(4'd0); enter(4'd9); enter(4'd9);
        check("load_099", 4'd0, 4'd9, 4'd9, 1'b0, 1'b0);
        mag_on = 1'b1;
        step(156);
        check("s99_39dec", 4'd0, 4'd6, 4'd0, 1'b0, 1'b0);
        step(4);
        check("s99_40dec", 4'd0, 4'd5, 4'd9, 1'b0, 1'b0);

        // Wrap cycle with mag_on low: no decrement, prescaler held.
        do_clear();
        enter(4'd2);
        mag_on = 1'b1;
        step(3);
        mag_on = 1'b0;
        step(1);
        check("wrap_paused", 4'd0, 4'd0, 4'd2, 1'b0, 1'b0);
        mag_on = 1'b1;
        step(1);
        check("wrap_resume", 4'd0, 4'd0, 4'd1, 1'b0, 1'b0);

        // Clear wins over entry and a wrap that would reach 0:00.
        do_clear();
        enter(4'd1);
        mag_on = 1'b1;
        step(3);
        clearn       = 1'b0;
        keypad_valid = 1'b1;
        keypad_digit = 4'd3;
        step(1);
        check("clr_wrap", 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        clearn       = 1'b1;
        keypad_valid = 1'b0;
        step(1);
        check("clr_wrap_nopulse", 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);

        // Clear while counting.
        do_clear();
        enter(4'd3); enter(4'd0);
        mag_on = 1'b1;
        step(5);
        check("count_30", 4'd0, 4'd2, 4'd9, 1'b0, 1'b0);
        clearn = 1'b0;
        step(1);
        check("clr_counting", 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        clearn = 1'b1;
        mag_on = 1'b0;

        // Asynchronous reset mid-run, then fresh entry.
        enter(4'd2); enter(4'd0); enter(4'd0);
        mag_on = 1'b1;
        step(6);
        check("run_159", 4'd1, 4'd5, 4'd9, 1'b0, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset", 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        mag_on = 1'b0;
        step(1);
        resetn = 1'b1;
        enter(4'd7);
        check("after_reset_7", 4'd0, 4'd0, 4'd7, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/microwave_timer.md
# microwave_timer

Countdown timer for the microwave oven controller: it accepts BCD digits from the keypad, holds a minutes:seconds setting, counts it down once per second while the magnetron is on, and drives `timer_done` back to the magnetron control block. It sits between the keypad decoder and the magnetron control. It also feeds the three-digit display (M:SS) and a one-cycle completion pulse for the beeper.

## Interface
- `TICKS_PER_SEC`, default 100: number of `clk` cycles per one-second tick; must be ≥ 2.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `resetn`  input  1  asynchronous, active-low reset.
- `clearn`  input  1  synchronous, active-low clear of the time setting.
- `keypad_valid`  input  1  one digit is presented in this cycle; level-sampled every cycle.
- `keypad_digit`  input  4  BCD digit, 0–9.
- `mag_on`  input  1  magnetron on; enables the countdown.
- `sec_ones`  output  4  BCD seconds units.
- `sec_tens`  output  4  BCD seconds tens.
- `min_ones`  output  4  BCD minutes.
- `timer_done`  output  1  high while the time is 0:00; combinational from the digit registers.
- `done_pulse`  output  1  one-cycle pulse when the countdown reaches 0:00.

## Operation
- **State.** Three 4-bit digit registers, a prescaler of width clog2(TICKS_PER_SEC), and the `done_pulse` register.
- **Priority per cycle.** Clear first, then digit entry, then countdown, then hold.
- **Clear (`clearn`=0).**
  - All digits go to 0 and the prescaler goes to 0.
  - Clear applies regardless of `mag_on`, so clearing while cooking raises `timer_done`.
- **Entry (`keypad_valid`=1, `mag_on`=0, digit ≤ 9).** The digits shift left:
  - `min_ones` takes the old `sec_tens`.
  - `sec_tens` takes the old `sec_ones`.
  - `sec_ones` takes `keypad_digit`.
  - The old `min_ones` is discarded.
  - The prescaler is reset to 0.
- **Entry is ignored when:**
  - `mag_on`=1, or
  - `keypad_digit` > 9.
- **Countdown (`mag_on`=1, time ≠ 0:00).**
  - The prescaler increments each cycle.
  - When the prescaler equals TICKS_PER_SEC−1, it wraps to 0 and the time decrements by one second.
- **Decrement rules.**
  - If `sec_ones` > 0: decrement `sec_ones`.
  - Else if `sec_tens` > 0: `sec_ones`=9, decrement `sec_tens`.
  - Else (`min_ones` > 0): `sec_tens`=5, `sec_ones`=9, decrement `min_ones`.
- **Seconds above 59.** Entered values such as 0:99 are legal. They count down 99, 98 … 00, then borrow to 59.
- **At 0:00.** No decrement is performed and the prescaler holds.
- **Pause (`mag_on`=0).** The prescaler holds its value, so resuming continues the partial second.
- **`done_pulse`.** Registered; it is 1 for exactly the cycle after a decrement that produced 0:00. Clear and reset never raise it.
- **Reset (`resetn`=0).**
  - Asynchronous, at any time, including mid-countdown.
  - All digits 0, prescaler 0, `done_pulse` 0, so `timer_done`=1.

## Timing
- **Entry latency.** A digit appears on the outputs one edge after the cycle in which `keypad_valid` is sampled. Holding `keypad_valid` high for N cycles enters N digits.
- **First decrement.** With a fresh prescaler, the first decrement happens on the TICKS_PER_SEC-th rising edge with `mag_on`=1, counting the first such edge as 1. Later decrements follow every TICKS_PER_SEC cycles.
- **Completion.** `timer_done` rises in the same cycle the digits become 0:00; `done_pulse` is high in that same cycle, for one cycle only.
- **Wrap cycle with `mag_on`=0.** No decrement and no prescaler change.
- **Clear during the wrap cycle.** Clear wins and no `done_pulse` is produced.
- **`resetn` release.** Takes effect on the next rising edge.

## Test plan
- **Reset value:** Reset → digits 0:00, `timer_done`=1, `done_pulse`=0. Then keypad 1,3,0 with `mag_on`=0 → display 1:30, `timer_done`=0.
- **Countdown with borrow:** TICKS_PER_SEC=4, load 1:00, `mag_on`=1.
  - First decrement on the 4th edge → 0:59.
  - Decrements every 4 cycles after that.
  - Exactly 60 decrements → 0:00, `timer_done`=1, a single `done_pulse`, then digits hold.
- **Pause and resume:** TICKS_PER_SEC=4, load 0:05, `mag_on` high for 6 cycles → 0:04. Drop `mag_on` for 10 cycles → still 0:04. Raise it again → 0:03 after 2 more cycles.
- **Illegal and blocked entry:**
  - Digit 12 → ignored.
  - Digits entered while `mag_on`=1 → ignored.
  - Digits 0,9,9 → 0:99, which counts down to 0:59 after 40 ticks.
- **Clear priority:** `clearn`=0 together with `keypad_valid`=1 and a wrap tick → 0:00, `done_pulse`=0. The same clear applied while counting with `mag_on`=1 also gives 0:00.
- **Asynchronous reset mid-run:** Load 2:00 and count. Assert `resetn`=0 between clock edges → outputs 0:00 immediately, without waiting for an edge. After release, a digit 7 → 0:07.
